// File: rtl/pulse_profile_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_profile_sched_pkg
//  Purpose  : Shared state encoding, mode codes and fixed-rate half periods.
//  Revision : 1.0
// ============================================================================
package pulse_profile_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIXED   = 2'd1,
        ST_PROFILE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] c_mode_32hz   = 2'd0;
    localparam logic [1:0] c_mode_64hz   = 2'd1;
    localparam logic [1:0] c_mode_128hz  = 2'd2;
    localparam logic [1:0] c_mode_profile = 2'd3;

    localparam logic [31:0] c_half_32hz  = 32'd1562500;
    localparam logic [31:0] c_half_64hz  = 32'd781250;
    localparam logic [31:0] c_half_128hz = 32'd390625;

    function automatic logic [31:0] half_for_mode(input logic [1:0] sel);
        case (sel)
            c_mode_64hz:  return c_half_64hz;
            c_mode_128hz: return c_half_128hz;
            default:      return c_half_32hz;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_profile_sched_sec_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sec_tick_gen
//  Purpose  : Free-running 0..CLK_HZ-1 counter with one-cycle terminal tick.
//  Revision : 1.0
// ============================================================================
module sec_tick_gen #(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int c_cnt_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(CLK_HZ - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign tick = (r_cnt == c_term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_profile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_profile_sched
//  Purpose  : Pulse-rate scheduler: fixed rates or a timed table of segments.
//  Revision : 1.0
// ============================================================================
module pulse_profile_sched
    import pulse_profile_sched_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int NSEG   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_div,
    input  logic [7:0]  wr_dur,
    output logic [31:0] half_period,
    output logic        pulse_en,
    output logic [3:0]  seg_idx,
    output logic        busy,
    output logic        done,
    output logic        wr_err,
    output logic        sec_tick
);

    localparam int c_idx_w = (NSEG > 1) ? $clog2(NSEG) : 1;

    logic [39:0]  r_table [0:NSEG-1];
    state_t       r_state;
    state_t       w_next_state;
    logic         r_start_d;
    logic [1:0]   r_fmode;
    logic [3:0]   r_seg;
    logic [7:0]   r_sec;

    logic         w_tick;
    logic         w_clr;
    logic         w_seg_adv;
    logic         w_last;
    logic         w_wr_in_range;
    logic         w_wr_ok;
    logic [3:0]   w_seg_next;
    logic [1:0]   w_fmode;
    logic [7:0]   w_cur_dur;
    logic [31:0]  w_cur_div;
    logic [7:0]   w_next_dur;

    assign w_seg_next    = r_seg + 4'd1;
    assign w_last        = (r_seg == 4'(NSEG - 1));
    assign w_cur_dur     = r_table[r_seg[c_idx_w-1:0]][7:0];
    assign w_cur_div     = r_table[r_seg[c_idx_w-1:0]][39:8];
    assign w_next_dur    = w_last ? 8'd0 : r_table[w_seg_next[c_idx_w-1:0]][7:0];
    assign w_fmode       = (mode != c_mode_profile) ? mode : r_fmode;
    assign w_wr_in_range = ({28'd0, wr_addr} < 32'(NSEG));
    assign w_wr_ok       = wr_en && (r_state != ST_PROFILE) && w_wr_in_range;
    // Restarting the second counter on every state change makes the first
    // second of any run exactly CLK_HZ cycles long.
    assign w_clr         = (w_next_state != r_state);
    assign sec_tick      = w_tick;

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_seg_adv    = 1'b0;
        if (!start) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_start_d) begin
                        w_next_state = (mode == c_mode_profile) ? ST_PROFILE : ST_FIXED;
                    end
                end
                ST_PROFILE: begin
                    if (w_cur_dur == 8'd0) begin
                        w_next_state = ST_DONE;
                    end else if (w_tick && (r_sec == w_cur_dur - 8'd1)) begin
                        w_seg_adv = 1'b1;
                        if (w_last || (w_next_dur == 8'd0)) begin
                            w_next_state = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_fmode     <= c_mode_32hz;
            r_seg       <= 4'd0;
            r_sec       <= 8'd0;
            half_period <= 32'd0;
            pulse_en    <= 1'b0;
            seg_idx     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            for (int i = 0; i < NSEG; i++) begin
                r_table[i] <= 40'd0;
            end
        end else begin
            r_state   <= w_next_state;
            r_start_d <= start;
            wr_err    <= wr_en && !w_wr_ok;
            if (w_wr_ok) begin
                r_table[wr_addr[c_idx_w-1:0]] <= {wr_div, wr_dur};
            end

            case (r_state)
                ST_IDLE: begin
                    r_seg   <= 4'd0;
                    r_sec   <= 8'd0;
                    r_fmode <= mode;
                end
                ST_FIXED: begin
                    r_fmode <= w_fmode;
                end
                ST_PROFILE: begin
                    if (w_seg_adv) begin
                        r_sec <= 8'd0;
                        if (w_next_state == ST_PROFILE) begin
                            r_seg <= w_seg_next;
                        end
                    end else if (w_tick) begin
                        r_sec <= r_sec + 8'd1;
                    end
                end
                default: begin
                end
            endcase

            busy    <= (r_state == ST_FIXED) || (r_state == ST_PROFILE);
            done    <= (r_state == ST_DONE);
            seg_idx <= r_seg;
            case (r_state)
                ST_FIXED: begin
                    half_period <= half_for_mode(w_fmode);
                    pulse_en    <= 1'b1;
                end
                ST_PROFILE: begin
                    half_period <= w_cur_div;
                    pulse_en    <= 1'b1;
                end
                default: begin
                    half_period <= 32'd0;
                    pulse_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_profile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_profile_sched
//  Purpose  : Directed self-checking bench for pulse_profile_sched.
//  Revision : 1.0
// ============================================================================
module tb_pulse_profile_sched;

    localparam int CLK_HZ = 10;
    localparam int NSEG   = 8;
    localparam int HMAX   = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_div = 32'd0;
    logic [7:0]  wr_dur = 8'd0;
    logic [31:0] half_period;
    logic        pulse_en;
    logic [3:0]  seg_idx;
    logic        busy;
    logic        done;
    logic        wr_err;
    logic        sec_tick;

    pulse_profile_sched #(
        .CLK_HZ (CLK_HZ),
        .NSEG   (NSEG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_div      (wr_div),
        .wr_dur      (wr_dur),
        .half_period (half_period),
        .pulse_en    (pulse_en),
        .seg_idx     (seg_idx),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err),
        .sec_tick    (sec_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] h_half [0:HMAX-1];
    logic        h_pe   [0:HMAX-1];
    logic        h_busy [0:HMAX-1];
    logic        h_tick [0:HMAX-1];
    logic [3:0]  h_seg  [0:HMAX-1];

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic [31:0] half;
        logic        pe;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [0:13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [31:0] d, input logic [7:0] u);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_div  = d;
        wr_dur  = u;
        @(negedge clk);
        check("wr_err_ok", 64'(wr_err), 64'd0);
        wr_en = 1'b0;
    endtask

    // Runs a profile from IDLE; h_*[k] holds outputs after the k-th edge following the start edge.
    task automatic run_profile(output int done_k);
        done_k = -1;
        start  = 1'b1;
        mode   = 2'd3;
        @(negedge clk);
        for (int k = 1; k < HMAX; k++) begin
            @(negedge clk);
            h_half[k] = half_period;
            h_pe[k]   = pulse_en;
            h_busy[k] = busy;
            h_tick[k] = sec_tick;
            h_seg[k]  = seg_idx;
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic int count_half(input logic [31:0] v, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) begin
            if (k > 0 && k < HMAX && h_half[k] == v) n++;
        end
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dk;
        int n_bad;
        int max_seg;

        vecs[0]  = '{1'b1, 2'd1, 32'd0,       1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 32'd781250,  1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 32'd390625,  1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 32'd1562500, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'd3, 32'd1562500, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 32'd781250,  1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 32'd781250,  1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 32'd0,       1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 32'd0,       1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd3, 32'd0,       1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 32'd0,       1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 32'd0,       1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 32'd0,       1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 32'd0,       1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, half_period, pulse_en, seg_idx, busy, done, wr_err},
              64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fixed rates, mode changes, stop, then an empty profile from the reset table.
        for (int i = 0; i < 14; i++) begin
            start = vecs[i].start;
            mode  = vecs[i].mode;
            @(negedge clk);
            check($sformatf("vec%0d", i), {29'd0, half_period, pulse_en, busy, done},
                  {29'd0, vecs[i].half, vecs[i].pe, vecs[i].busy, vecs[i].done});
        end

        // Three-segment profile.
        write_entry(4'd0, 32'd100, 8'd2);
        write_entry(4'd1, 32'd50, 8'd1);
        write_entry(4'd2, 32'd0, 8'd0);
        run_profile(dk);
        check("prof_done_cycle", 64'(dk), 64'd31);
        check("prof_n100", 64'(count_half(32'd100, 1, 31)), 64'd20);
        check("prof_n50", 64'(count_half(32'd50, 1, 31)), 64'd10);
        check("prof_edge_20_21", {h_half[20], h_half[21]}, {32'd100, 32'd50});
        check("prof_done_outputs", {31'd0, h_half[31], h_pe[31]}, 64'd0);
        check("prof_seg1", 64'(h_seg[25]), 64'd1);
        check("prof_first_tick", {62'd0, h_tick[8], h_tick[9]}, 64'd1);

        // Stop at cycle 15, then restart from segment 0.
        start = 1'b1;
        mode  = 2'd3;
        @(negedge clk);
        repeat (15) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drop_idle", {30'd0, half_period, pulse_en, busy}, 64'd0);
        run_profile(dk);
        check("restart_seg0", 64'(h_seg[1]), 64'd0);
        check("restart_n100", 64'(count_half(32'd100, 1, 31)), 64'd20);
        check("restart_done", 64'(dk), 64'd31);

        // Rejected writes: during PROFILE and out of range.
        start = 1'b1;
        mode  = 2'd3;
        @(negedge clk);
        repeat (3) @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_div  = 32'd999;
        wr_dur  = 8'd7;
        @(negedge clk);
        check("wr_err_profile", 64'(wr_err), 64'd1);
        wr_en = 1'b0;
        @(negedge clk);
        check("wr_err_profile_clr", 64'(wr_err), 64'd0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'(NSEG);
        wr_div  = 32'd777;
        wr_dur  = 8'd5;
        @(negedge clk);
        check("wr_err_range", 64'(wr_err), 64'd1);
        wr_en = 1'b0;
        @(negedge clk);
        check("wr_err_range_clr", 64'(wr_err), 64'd0);
        run_profile(dk);
        check("table_kept_done", 64'(dk), 64'd31);
        check("table_kept_n100", 64'(count_half(32'd100, 1, 31)), 64'd20);
        check("table_kept_n50", 64'(count_half(32'd50, 1, 31)), 64'd10);

        // Full table of one-second segments.
        for (int i = 0; i < NSEG; i++) begin
            write_entry(4'(i), 32'(10 + i), 8'd1);
        end
        run_profile(dk);
        check("full_done_cycle", 64'(dk), 64'(NSEG * 10 + 1));
        n_bad   = 0;
        max_seg = 0;
        for (int k = 1; k <= NSEG * 10; k++) begin
            if (h_half[k] != 32'(10 + int'(h_seg[k])) || h_pe[k] !== 1'b1) n_bad++;
            if (int'(h_seg[k]) > max_seg) max_seg = int'(h_seg[k]);
        end
        check("full_div_track", 64'(n_bad), 64'd0);
        check("full_max_seg", 64'(max_seg), 64'(NSEG - 1));

        // Asynchronous reset mid-segment, then an empty table.
        start = 1'b1;
        mode  = 2'd3;
        @(negedge clk);
        repeat (15) @(negedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("async_reset", {25'd0, half_period, pulse_en, seg_idx, busy, done},
              64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_profile(dk);
        check("empty_done_cycle", 64'(dk), 64'd2);
        check("empty_entry", {31'd0, h_half[1], h_busy[1]}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
